// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The state encoding is exported so checkers can decode the debug state output.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // Little-endian lane insert: byte k lands in bits [8k+7:8k].
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs consecutive bytes into a 32-bit little-endian word; reused for the
// length header and for every data word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        full,
  output logic [31:0] word_next,
  output logic [1:0]  idx
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  // full marks the byte that completes a group; word_next already holds it.
  always_comb begin
    idx_d     = idx_q;
    word_d    = word_q;
    full      = 1'b0;
    word_next = word_q;
    if (clear) begin
      idx_d  = 2'd0;
      word_d = 32'd0;
    end else if (in_valid) begin
      word_next = insert_byte(word_q, idx_q, in_byte);
      word_d    = word_next;
      idx_d     = idx_q + 2'd1;
      full      = (idx_q == 2'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a length-prefixed little-endian byte stream, writes the
// words into instruction memory and releases the core reset when finished.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              core_rst_n,
  output logic              done,
  output logic              err,
  output loader_state_t     dbg_state
);

  // Handshakes: a byte moves on rx_valid & rx_ready; a write completes on
  // mem_we & mem_ready, with mem_addr/mem_wdata held until that cycle.

  loader_state_t     state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       idx_q, idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_rst_n_q, core_rst_n_d;

  logic              byte_fire;
  logic              pk_full;
  logic [31:0]       pk_word;
  logic [1:0]        pk_idx;
  logic [31:0]       idx_inc;

  assign rx_ready  = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign mem_we    = (state_q == ST_WRITE);
  assign byte_fire = rx_valid & rx_ready;
  assign idx_inc   = idx_q + 32'd1;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (~rx_ready),
    .in_valid  (byte_fire),
    .in_byte   (rx_data),
    .full      (pk_full),
    .word_next (pk_word),
    .idx       (pk_idx)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    core_rst_n_d = core_rst_n_q;
    case (state_q)
      ST_LEN: begin
        if (pk_full) begin
          count_d = pk_word;
          if (pk_word == 32'd0) begin
            state_d      = ST_DONE;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
          end else if (pk_word > 32'(MAX_WORDS)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pk_full) begin
          mem_wdata_d = pk_word;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          idx_d = idx_inc;
          // Byte address wraps silently at the top of the address space.
          mem_addr_d = BASE_ADDR + ADDR_W'({idx_inc, 2'b00});
          if (idx_inc == count_q) begin
            state_d      = ST_DONE;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LEN;
      count_q      <= 32'd0;
      idx_q        <= 32'd0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign core_rst_n = core_rst_n_q;
  assign dbg_state  = state_q;

  logic unused_ok;
  assign unused_ok = ^pk_idx;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drivers push expected writes into a queue,
// a negedge monitor pops and compares every completed imem write.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic          core_rst_n;
  logic          done;
  logic          err;
  loader_state_t dbg_state;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted write must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr", mem_addr, mon_exp[63:32]);
        check("write_data", mem_wdata, mon_exp[31:0]);
      end
    end
  end

  task automatic apply_reset();
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offers one byte and returns #1 after the edge on which it transferred.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1 rx_valid = 1'b0;
        return;
      end
    end
    rx_valid = 1'b0;
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: got rx_ready 0 for 50 cycles expected 1 (byte %h)", b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  int w0;
  int stuck;

  initial begin
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mem_ready = 1'b1;
    #3;
    check_reset_outputs("reset");

    // Basic load: two words, imem always ready.
    apply_reset();
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h0050_0093});
    send_word(32'h0000_0002);
    send_word(32'h0000_0013);
    send_word(32'h0050_0093);
    @(negedge clk);
    check("basic_we_last", {31'd0, mem_we}, 32'd1);
    check("basic_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    check("basic_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("basic_we_off", {31'd0, mem_we}, 32'd0);
    check("basic_queue", exp_q.size(), 32'd0);

    // Empty image.
    apply_reset();
    w0 = n_writes;
    send_word(32'h0000_0000);
    @(negedge clk);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    check("empty_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("empty_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    check("empty_no_write", n_writes - w0, 32'd0);

    // Oversize length: MAX_WORDS + 1.
    apply_reset();
    w0 = n_writes;
    send_word(32'h0000_0401);
    @(negedge clk);
    check("over_err", {31'd0, err}, 32'd1);
    check("over_done", {31'd0, done}, 32'd0);
    check("over_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    stuck = 0;
    repeat (6) begin
      @(negedge clk);
      if (rx_ready || mem_we) stuck++;
    end
    rx_valid = 1'b0;
    check("over_quiet", stuck, 32'd0);
    check("over_no_write", n_writes - w0, 32'd0);
    check("over_err_sticky", {31'd0, err}, 32'd1);

    // imem backpressure: three mem_ready-low cycles on the first write.
    apply_reset();
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    exp_q.push_back({32'h4, 32'h1234_5678});
    send_word(32'h0000_0002);
    mem_ready = 1'b0;
    send_word(32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_we", {31'd0, mem_we}, 32'd1);
      check("bp_addr", mem_addr, 32'h0);
      check("bp_data", mem_wdata, 32'hDEAD_BEEF);
      check("bp_rx_ready", {31'd0, rx_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("bp_we_4th", {31'd0, mem_we}, 32'd1);
    check("bp_data_4th", mem_wdata, 32'hDEAD_BEEF);
    check("bp_rx_ready_4th", {31'd0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'h78;
    @(negedge clk);
    check("bp_next_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    wait_done("bp_done");
    check("bp_queue", exp_q.size(), 32'd0);

    // rx_valid gaps between the bytes of one word.
    apply_reset();
    exp_q.push_back({32'h0, 32'h0050_0093});
    send_word(32'h0000_0001);
    send_byte(8'h93);
    rx_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h00);
    rx_data = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h50);
    rx_data = 8'hC3;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h00);
    wait_done("gap_done");
    check("gap_queue", exp_q.size(), 32'd0);

    // Reset pulse in the middle of the second word.
    apply_reset();
    exp_q.push_back({32'h0, 32'h1122_3344});
    send_word(32'h0000_0002);
    send_word(32'h1122_3344);
    @(negedge clk);
    send_byte(8'hA1);
    send_byte(8'hB2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back({32'h0, 32'hCAFE_F00D});
    send_word(32'h0000_0001);
    send_word(32'hCAFE_F00D);
    wait_done("midrst_done");
    check("midrst_queue", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the BearCore-V core. It takes a byte stream from a debug/UART receiver, packs it into 32-bit little-endian words, and writes them into the instruction memory that the core's ROM/imem port later reads. It holds the core in reset until the image is fully written, then releases it. It is the write-side counterpart of the `simple_rom` read path (`addr` in, `inst` out).

## Interface
- `ADDR_W`, 32: width of `mem_addr`.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, 1024: largest legal image length in words.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `rx_valid` input 1: a byte is offered on `rx_data`.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: loader accepts a byte. A byte transfers when `rx_valid & rx_ready` is high.
- `mem_we` output 1: write request to imem.
- `mem_addr` output ADDR_W: byte address of the write, always word-aligned.
- `mem_wdata` output 32: write data.
- `mem_ready` input 1: imem accepts the write in the current cycle.
- `core_rst_n` output 1: active-low reset to the core.
- `done` output 1: image loaded. Sticky until reset.
- `err` output 1: length error. Sticky until reset.

## Operation
- Stream format:
  - 4-byte little-endian word count N.
  - Then N words, each 4 bytes, little-endian. Byte k of a group goes to bits [8k+7:8k].
- FSM states: LEN, DATA, WRITE, DONE, ERR. The reset state is LEN.
- **LEN**
  - `rx_ready`=1; accept 4 bytes into the count register.
  - After the 4th byte:
    - N==0 → DONE.
    - N>MAX_WORDS → ERR.
    - Otherwise → DATA.
- **DATA**
  - `rx_ready`=1; accept 4 bytes into the word register.
  - After the 4th byte → WRITE.
- **WRITE**
  - `rx_ready`=0, `mem_we`=1.
  - `mem_addr` = BASE_ADDR + 4·idx, and `mem_wdata` = the assembled word. Both are held stable until `mem_ready` is high.
  - On the `mem_ready` cycle, idx increments.
  - Then: idx+1==N → DONE, otherwise → DATA.
- **DONE**: `done`=1, `core_rst_n`=1, `rx_ready`=0. Terminal state.
- **ERR**: `err`=1, `core_rst_n`=0, `rx_ready`=0. Terminal state.
- Arithmetic:
  - idx and N are 32 bits wide.
  - Address arithmetic wraps modulo 2^ADDR_W with no error.
  - The byte-index counter is 2 bits and wraps 3→0.
- `rx_ready` and `mem_we` are combinational decodes of the state. All other outputs are registered.
- `rx_valid` gaps stall assembly without losing partial bytes.
- Bytes presented while `rx_ready`=0 are not consumed.

## Timing
- Reset values:
  - State LEN, all counters 0.
  - `rx_ready`=1, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0.
  - `core_rst_n`=0, `done`=0, `err`=0.
- If the 4th data byte is accepted in cycle t:
  - `mem_we`=1 in cycle t+1.
  - If `mem_ready`=1 in t+1, `rx_ready`=1 again in t+2.
- Minimum throughput is 5 cycles per word.
- Each `mem_ready`-low cycle adds one cycle. No timeout.
- If the 4th header byte is accepted in cycle t, then in t+1 exactly one of these holds: `rx_ready`=1, `done`=1, or `err`=1.
- `done`/`core_rst_n` rise one cycle after the final `mem_ready` cycle.
- Reset mid-operation:
  - All outputs return to their reset values immediately, asynchronously.
  - `mem_we` drops.
  - The partial word is discarded.
  - The next stream restarts at BASE_ADDR.

## Structure
- `imem_loader_pkg`:
  - State enum `loader_state_t`.
  - `HDR_BYTES`=4, `WORD_BYTES`=4.
- Sub-module `byte_packer`: 2-bit index counter plus 32-bit little-endian shift/insert register, with `clear` and `full` outputs. It is reused for both the header and the data words.

## Test plan
- **Basic load**: stream 02 00 00 00, 13 00 00 00, 93 00 50 00 with `mem_ready`=1.
  - Writes (0x0, 0x00000013) then (0x4, 0x00500093).
  - `done`=1 and `core_rst_n`=1 one cycle after the 2nd write; `rx_ready`=0 afterwards.
- **Empty image**: header 00 00 00 00 → `done`=1 the cycle after the 4th byte; `mem_we` never asserted.
- **Oversize length**: header N=MAX_WORDS+1 (01 04 00 00 at 1024) → `err`=1, `core_rst_n`=0, no `mem_we`, `rx_ready`=0 permanently.
- **imem backpressure**: `mem_ready` held low 3 cycles during the first write → `mem_we`, `mem_addr`, `mem_wdata` stable for 4 cycles; `rx_ready`=0 throughout; next byte accepted the cycle after the write completes.
- **Byte-valid gaps**: `rx_valid` toggled 1-0-0-1 between bytes of word 0x00500093 → identical write data; no byte duplicated or dropped.
- **Reset mid-word**: `rst_n` pulsed low after 2 of 4 data bytes → all outputs at their reset values during the pulse; a fresh 1-word stream then writes to BASE_ADDR with the correct data.
